// File: rtl/pulse_sync_scheduler.sv
// Round-robin scheduler that shares one pulse-synchronizer channel among N_REQ
// requesters, counting pending events and spacing pulses by a programmable hold-off.
module pulse_sync_scheduler #(
   parameter int N_REQ = 4,
   parameter int CNT_W = 3,
   parameter int GAP   = 8,
   localparam int ID_W = $clog2(N_REQ)
) (
   input  logic             clksrc,
   input  logic             resetb_clksrc,
   input  logic             enable,
   input  logic [N_REQ-1:0] req_pulse,
   input  logic             ovf_clear,
   output logic             pulse_out,
   output logic [ID_W-1:0]  id_out,
   output logic             busy,
   output logic             pending_any,
   output logic [N_REQ-1:0] overflow
);

   // state | meaning
   // IDLE  | waiting for enable and a nonzero pending counter
   // ISSUE | pulse_out high for this single cycle
   // HOLD  | GAP-cycle hold-off while the synchronizer re-arms
   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   localparam int GAP_W = $clog2(GAP + 1);

   state_t           state_q;
   logic             pulse_q;
   logic [ID_W-1:0]  id_q;
   logic [ID_W-1:0]  last_q;
   logic [GAP_W-1:0] gap_q;
   logic [CNT_W-1:0] cnt_q [N_REQ];
   logic [CNT_W-1:0] cnt_d [N_REQ];
   logic [N_REQ-1:0] ovf_q;
   logic [N_REQ-1:0] ovf_d;
   logic [ID_W-1:0]  winner;
   logic             found;
   logic             grant;
   int               idx;

   // Search starts just after the last winner so every requester gets a turn.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int off = 1; off <= N_REQ; off++) begin
         idx = int'(last_q) + off;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && (cnt_q[ID_W'(idx)] != '0)) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
   end

   always_comb begin
      pending_any = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (cnt_q[i] != '0) pending_any = 1'b1;
      end
   end

   assign grant = (state_q == IDLE) && enable && found;

   // A fresh overflow takes priority over ovf_clear in the same cycle.
   always_comb begin
      ovf_d = ovf_clear ? '0 : ovf_q;
      for (int i = 0; i < N_REQ; i++) begin
         cnt_d[i] = cnt_q[i];
         if (req_pulse[i] && !(grant && (winner == ID_W'(i)))) begin
            if (cnt_q[i] == {CNT_W{1'b1}}) ovf_d[i] = 1'b1;
            else                           cnt_d[i] = cnt_q[i] + 1'b1;
         end else if (!req_pulse[i] && grant && (winner == ID_W'(i))) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clksrc) begin
      if (!resetb_clksrc) begin
         for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
         ovf_q   <= '0;
         state_q <= IDLE;
         pulse_q <= 1'b0;
         id_q    <= '0;
         last_q  <= ID_W'(N_REQ - 1);
         gap_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         case (state_q)
            IDLE: begin
               pulse_q <= 1'b0;
               if (grant) begin
                  state_q <= ISSUE;
                  pulse_q <= 1'b1;
                  id_q    <= winner;
                  last_q  <= winner;
               end
            end
            ISSUE: begin
               pulse_q <= 1'b0;
               gap_q   <= GAP_W'(GAP - 1);
               state_q <= HOLD;
            end
            HOLD: begin
               pulse_q <= 1'b0;
               if (gap_q == '0) state_q <= IDLE;
               else             gap_q   <= gap_q - 1'b1;
            end
            default: begin
               pulse_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign pulse_out = pulse_q;
   assign id_out    = id_q;
   assign busy      = (state_q != IDLE);
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_sync_scheduler.sv
// Directed bench for pulse_sync_scheduler (N_REQ=4, CNT_W=3, GAP=8): inputs are
// driven and outputs sampled on the falling edge.
module tb_pulse_sync_scheduler;

   logic       clksrc = 1'b0;
   logic       resetb_clksrc;
   logic       enable;
   logic [3:0] req_pulse;
   logic       ovf_clear;
   logic       pulse_out;
   logic [1:0] id_out;
   logic       busy;
   logic       pending_any;
   logic [3:0] overflow;

   int checks = 0;
   int errors = 0;
   int dly;
   int npulse;

   pulse_sync_scheduler #(.N_REQ(4), .CNT_W(3), .GAP(8)) dut (
      .clksrc        (clksrc),
      .resetb_clksrc (resetb_clksrc),
      .enable        (enable),
      .req_pulse     (req_pulse),
      .ovf_clear     (ovf_clear),
      .pulse_out     (pulse_out),
      .id_out        (id_out),
      .busy          (busy),
      .pending_any   (pending_any),
      .overflow      (overflow)
   );

   always #5 clksrc = ~clksrc;

   task automatic tick();
      @(posedge clksrc);
      @(negedge clksrc);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic do_reset();
      resetb_clksrc = 1'b0;
      enable        = 1'b0;
      ovf_clear     = 1'b0;
      req_pulse     = 4'b0000;
      tick();
      tick();
      resetb_clksrc = 1'b1;
   endtask

   task automatic strobe(input logic [3:0] v);
      req_pulse = v;
      tick();
      req_pulse = 4'b0000;
   endtask

   // Ticks until pulse_out is seen; d is the tick count, or -1 if none within max.
   task automatic wait_pulse(input int max, output int d);
      d = -1;
      for (int k = 1; k <= max; k++) begin
         tick();
         if (pulse_out) begin
            d = k;
            break;
         end
      end
   endtask

   initial begin
      // Reset with requests asserted: they must be discarded.
      resetb_clksrc = 1'b0;
      enable        = 1'b1;
      ovf_clear     = 1'b0;
      req_pulse     = 4'b1111;
      tick();
      tick();
      req_pulse     = 4'b0000;
      check("rst_pulse", 32'(pulse_out), 0);
      check("rst_id", 32'(id_out), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_pending", 32'(pending_any), 0);
      check("rst_ovf", 32'(overflow), 0);
      resetb_clksrc = 1'b1;
      tick();
      tick();
      tick();
      check("rst_discard_busy", 32'(busy), 0);
      check("rst_discard_pend", 32'(pending_any), 0);

      // Single event on requester 2
      strobe(4'b0100);
      check("single_c1_pend", 32'(pending_any), 1);
      check("single_c1_pulse", 32'(pulse_out), 0);
      check("single_c1_busy", 32'(busy), 0);
      tick();
      check("single_c2_pulse", 32'(pulse_out), 1);
      check("single_c2_id", 32'(id_out), 2);
      check("single_c2_busy", 32'(busy), 1);
      check("single_c2_pend", 32'(pending_any), 0);
      for (int c = 3; c <= 10; c++) begin
         tick();
         check($sformatf("single_c%0d_pulse", c), 32'(pulse_out), 0);
         check($sformatf("single_c%0d_busy", c), 32'(busy), 1);
      end
      tick();
      check("single_c11_busy", 32'(busy), 0);
      check("single_c11_id", 32'(id_out), 2);

      // Round-robin over all four requesters
      do_reset();
      enable = 1'b1;
      strobe(4'b1111);
      wait_pulse(30, dly);
      check("rr0_delay", 32'(dly), 1);
      check("rr0_id", 32'(id_out), 0);
      for (int n = 1; n <= 3; n++) begin
         wait_pulse(30, dly);
         check($sformatf("rr%0d_delay", n), 32'(dly), 10);
         check($sformatf("rr%0d_id", n), 32'(id_out), 32'(n));
      end
      wait_pulse(30, dly);
      check("rr_no_more", 32'(dly), -1);
      check("rr_idle_busy", 32'(busy), 0);

      // Saturation and overflow
      do_reset();
      req_pulse = 4'b0010;
      repeat (9) tick();
      req_pulse = 4'b0000;
      check("sat_ovf", 32'(overflow), 32'h2);
      check("sat_pend", 32'(pending_any), 1);
      check("sat_busy", 32'(busy), 0);
      ovf_clear = 1'b1;
      tick();
      ovf_clear = 1'b0;
      check("sat_clear", 32'(overflow), 0);
      ovf_clear = 1'b1;
      req_pulse = 4'b0010;
      tick();
      ovf_clear = 1'b0;
      req_pulse = 4'b0000;
      check("sat_set_wins", 32'(overflow), 32'h2);
      ovf_clear = 1'b1;
      tick();
      ovf_clear = 1'b0;
      check("sat_clear2", 32'(overflow), 0);
      enable = 1'b1;
      wait_pulse(30, dly);
      check("sat_p0_delay", 32'(dly), 1);
      check("sat_p0_id", 32'(id_out), 1);
      npulse = 1;
      for (int n = 1; n < 7; n++) begin
         wait_pulse(30, dly);
         if (dly == 10 && id_out == 2'd1) npulse++;
      end
      check("sat_pulse_count", 32'(npulse), 7);
      wait_pulse(30, dly);
      check("sat_no_8th", 32'(dly), -1);
      check("sat_pend_end", 32'(pending_any), 0);

      // Increment coinciding with the grant to the same requester
      do_reset();
      enable = 1'b1;
      strobe(4'b0001);
      req_pulse = 4'b0001;
      tick();
      req_pulse = 4'b0000;
      check("simul_pulse", 32'(pulse_out), 1);
      check("simul_pend", 32'(pending_any), 1);
      wait_pulse(30, dly);
      check("simul_2nd_delay", 32'(dly), 10);
      check("simul_2nd_id", 32'(id_out), 0);
      check("simul_pend_end", 32'(pending_any), 0);
      wait_pulse(30, dly);
      check("simul_no_3rd", 32'(dly), -1);

      // Enable dropped during HOLD
      do_reset();
      enable = 1'b1;
      strobe(4'b0001);
      tick();
      check("gate_pulse", 32'(pulse_out), 1);
      tick();
      tick();
      enable    = 1'b0;
      req_pulse = 4'b0100;
      tick();
      tick();
      req_pulse = 4'b0000;
      check("gate_hold_busy", 32'(busy), 1);
      npulse = 0;
      for (int c = 7; c <= 20; c++) begin
         tick();
         if (pulse_out) npulse++;
      end
      check("gate_no_pulse", 32'(npulse), 0);
      check("gate_idle_busy", 32'(busy), 0);
      check("gate_pend", 32'(pending_any), 1);
      enable = 1'b1;
      tick();
      check("gate_reen_pulse", 32'(pulse_out), 1);
      check("gate_reen_id", 32'(id_out), 2);
      wait_pulse(30, dly);
      check("gate_2nd_delay", 32'(dly), 10);
      check("gate_2nd_id", 32'(id_out), 2);

      // Reset during HOLD
      do_reset();
      enable = 1'b1;
      strobe(4'b1111);
      tick();
      check("mid_pulse", 32'(pulse_out), 1);
      check("mid_id", 32'(id_out), 0);
      tick();
      tick();
      tick();
      resetb_clksrc = 1'b0;
      tick();
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_pulse", 32'(pulse_out), 0);
      check("mid_rst_id", 32'(id_out), 0);
      check("mid_rst_pend", 32'(pending_any), 0);
      resetb_clksrc = 1'b1;
      strobe(4'b1001);
      wait_pulse(30, dly);
      check("mid_after_delay", 32'(dly), 1);
      check("mid_after_id", 32'(id_out), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pulse_sync_scheduler.md
Name: pulse_sync_scheduler

Overview:
- Source-domain scheduler that shares one pulse-synchronizer channel among N_REQ event requesters.
- Counts pending single-cycle events per requester and grants them round-robin, one at a time.
- Issues one pulse per grant to the synchronizer input, with a requester ID held stable beside it.
- Enforces a programmable hold-off between pulses, so no pulse arrives while the synchronizer's stretched/ack handshake is still in flight.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- CNT_W, 3, width of each pending-event counter; saturates at 2^CNT_W-1.
- GAP, 8, hold-off cycles after each issued pulse (>=1). Integrator sets GAP >= 3*ceil(Tclkdest/Tclksrc)+4 so the synchronizer has re-armed.
- ID_W, $clog2(N_REQ), derived localparam, width of id_out.

Ports:
- clksrc  in  1  source-domain clock; all logic is on its rising edge.
- resetb_clksrc  in  1  synchronous, active-low reset.
- enable  in  1  permits new grants; low blocks grants but not counting.
- req_pulse  in  N_REQ  per-requester event strobe; one event per high cycle per bit.
- ovf_clear  in  1  clears all overflow flags.
- pulse_out  out  1  single-cycle pulse to the synchronizer's pulse_src.
- id_out  out  ID_W  requester granted by the most recent pulse_out; held until the next grant.
- busy  out  1  high when the FSM is not IDLE.
- pending_any  out  1  OR of (counter[i] != 0).
- overflow  out  N_REQ  sticky per-requester event-lost flags.

Behaviour:
- Reset (resetb_clksrc low at a clksrc edge):
  - counters=0, overflow=0, state=IDLE, pulse_out=0, id_out=0, busy=0, pending_any=0.
  - Round-robin pointer last_grant=N_REQ-1, so requester 0 has first priority.
  - req_pulse sampled during reset is discarded.
  - Reset mid-HOLD or mid-ISSUE aborts immediately; pending events are lost.
- Counters:
  - req_pulse[i]=1 increments counter[i]; a grant to i decrements counter[i].
  - Increment and grant to i in the same cycle: counter unchanged.
  - req_pulse[i]=1 with counter at max and no simultaneous grant to i: counter stays at max, overflow[i] set, event dropped.
- ovf_clear=1 clears all overflow bits. A new overflow in the same cycle wins: that bit stays set.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE:
    - Stays in IDLE unless enable=1 and any counter != 0 (registered values).
    - On a grant: winner = first nonzero counter searching last_grant+1, +2, ... with wrap modulo N_REQ.
    - At that edge: counter[winner] decrements, id_out<=winner, last_grant<=winner, state<=ISSUE.
  - ISSUE:
    - pulse_out=1 for exactly this one cycle.
    - Gap counter loads GAP-1; state<=HOLD.
  - HOLD:
    - pulse_out=0; gap counter decrements each cycle.
    - When the gap counter is 0, state<=IDLE; HOLD lasts exactly GAP cycles.
    - enable is ignored in ISSUE and HOLD; an in-flight sequence always completes.
- Timing:
  - req_pulse high at cycle 0 with FSM IDLE and enable=1: pulse_out high at cycle 2.
  - Back-to-back pulses under continuous demand are spaced exactly GAP+2 cycles apart.
- Outputs:
  - pulse_out is registered; it is never high in two consecutive cycles.
  - id_out changes only on the IDLE->ISSUE edge.
  - busy = (state != IDLE); pending_any is combinational from the registered counters.
- Fairness: with all requesters continuously pending, grants rotate 0,1,..,N_REQ-1,0,...

Test Plan:
- Single event: reset, enable=1, req_pulse=4'b0100 at cycle 0 -> pulse_out=1 only at cycle 2, id_out=2, busy high cycles 2..2+GAP, pending_any=0 from cycle 2.
- Round-robin: req_pulse=4'b1111 for 1 cycle, GAP=8 -> pulses at cycles 2,12,22,32 with id_out 0,1,2,3, then idle.
- Saturation: CNT_W=3, req_pulse[1] held 9 cycles with enable=0 -> counter[1]=7, overflow[1]=1. ovf_clear pulse -> overflow[1]=0. Enable -> exactly 7 pulses with id_out=1.
- Simultaneous increment and grant: requester 0 with counter 1, req_pulse[0]=1 on the grant edge -> counter stays 1; a second pulse follows GAP+2 cycles later.
- Enable gating: enable dropped during HOLD -> current HOLD completes, FSM stays IDLE, counters keep accumulating. Re-enable -> grant next cycle.
- Reset mid-HOLD: resetb_clksrc low for 1 cycle during HOLD with counters nonzero -> next cycle state=IDLE, counters 0, pulse_out 0, id_out 0, requester 0 highest priority.
